piezo_tone_gen: RTL

- Parametrised keypad-to-piezo tone generator for N keys.
- One shared half-period counter replaces one free-running divider per key; the divider is reloaded from a per-key half-period table.
- Adds key synchronisation, lowest-index priority selection, octave shift, a global mute, and glitch-free note changes at half-cycle boundaries.
- Sits between the keypad scanner outputs and the piezo pin.

---
 rtl/piezo_pkg.sv | 25 ++
 rtl/piezo_key_sync.sv | 48 ++++
 rtl/piezo_tone_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/piezo_pkg.sv
// Shared defaults, FSM state type and the half-period shift helper for the piezo tone generator.
package piezo_pkg;

    localparam int unsigned DefaultCntW    = 12;
    localparam int unsigned DefaultNumKeys = 12;

    // Entry 0 sits in the LSBs.
    localparam logic [DefaultNumKeys*DefaultCntW-1:0] DefaultHalfPeriods = {
        12'd1600, 12'd1800, 12'd1702, 12'd1911, 12'd2024, 12'd2272,
        12'd2551, 12'd2863, 12'd3033, 12'd3405, 12'd3822, 12'd1516
    };

    typedef enum logic [0:0] {
        StIdle,
        StPlay
    } piezo_state_e;

    function automatic logic [31:0] clamp_shift(input logic [31:0] period,
                                                input logic [31:0] octave);
        logic [31:0] shifted;
        shifted = period >> octave;
        return (shifted == 32'd0) ? 32'd1 : shifted;
    endfunction

endpackage

// File: rtl/piezo_key_sync.sv
// Two-flop key synchroniser followed by a registered lowest-index priority encoder.
module piezo_key_sync
    import piezo_pkg::*;
#(
    parameter int unsigned NUM_KEYS = DefaultNumKeys,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys_i,
    output logic                any_key_o,
    output logic [IDX_W-1:0]    sel_o
);

    logic [NUM_KEYS-1:0] meta_q;
    logic [NUM_KEYS-1:0] sync_q;
    logic                any_q;
    logic [IDX_W-1:0]    sel_q;
    logic [IDX_W-1:0]    sel_d;

    // Scan from the top down so the lowest held index is the last one written.
    always_comb begin
        sel_d = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (sync_q[i]) begin
                sel_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            any_q  <= 1'b0;
            sel_q  <= '0;
        end else begin
            meta_q <= keys_i;
            sync_q <= meta_q;
            any_q  <= |sync_q;
            sel_q  <= sel_d;
        end
    end

    assign any_key_o = any_q;
    assign sel_o     = sel_q;

endmodule

// File: rtl/piezo_tone_gen.sv
// Keypad-to-piezo tone generator: one shared half-period counter reloaded from a per-key table.
module piezo_tone_gen
    import piezo_pkg::*;
#(
    parameter int unsigned                 NUM_KEYS     = DefaultNumKeys,
    parameter int unsigned                 CNT_W        = DefaultCntW,
    parameter logic [NUM_KEYS*CNT_W-1:0]   HALF_PERIODS = DefaultHalfPeriods,
    parameter int unsigned                 OCT_W        = 2,
    localparam int unsigned                IdxW         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                en,
    input  logic [OCT_W-1:0]    octave,
    output logic                piezo,
    output logic                active,
    output logic [IdxW-1:0]     note_idx
);

    logic            any_key;
    logic            any;
    logic [IdxW-1:0] sel;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] eff;
    logic [CNT_W-1:0] reload;

    piezo_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             piezo_q;
    logic             active_q;
    logic [IdxW-1:0]  note_q;

    piezo_key_sync #(
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (IdxW)
    ) u_key_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .keys_i    (keys),
        .any_key_o (any_key),
        .sel_o     (sel)
    );

    assign any = any_key & en;

    always_comb begin
        base = '0;
        for (int k = 0; k < int'(NUM_KEYS); k++) begin
            if (sel == IdxW'(k)) begin
                base = HALF_PERIODS[k*CNT_W +: CNT_W];
            end
        end
        eff    = CNT_W'(clamp_shift(32'(base), 32'(octave)));
        reload = eff - 1'b1;
    end

    // Note, octave and enable are only sampled at a half-cycle boundary (cnt_q == 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            piezo_q  <= 1'b0;
            active_q <= 1'b0;
            note_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    piezo_q <= 1'b0;
                    cnt_q   <= '0;
                    if (any) begin
                        state_q  <= StPlay;
                        active_q <= 1'b1;
                        cnt_q    <= reload;
                        note_q   <= sel;
                    end
                end
                StPlay: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (any) begin
                        piezo_q <= ~piezo_q;
                        cnt_q   <= reload;
                        note_q  <= sel;
                    end else begin
                        piezo_q  <= 1'b0;
                        state_q  <= StIdle;
                        active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    active_q <= 1'b0;
                    piezo_q  <= 1'b0;
                end
            endcase
        end
    end

    assign piezo    = piezo_q;
    assign active   = active_q;
    assign note_idx = note_q;

endmodule
